// File: rtl/mod_arith_pkg.sv
// Shared types and sizing helpers for the modular add/sub datapath.
package mod_arith_pkg;

  localparam int WIDTH_DEF  = 1027;
  localparam int LIMB_W_DEF = 256;

  // ceil((w+1)/l): leaves room for the carry out of a+b
  function automatic int nlimb(input int w, input int l);
    return (w + l) / l;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PASS1,
    PASS2,
    DONE
  } state_e;

endpackage

// File: rtl/limb_adder.sv
// One limb of the shared carry chain: sum = x + (inv ? ~y : y) + cin.
module limb_adder #(
  parameter int W = 256
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         inv_y_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] y_eff;

  assign y_eff = y_i ^ {W{inv_y_i}};

  assign {cout_o, sum_o} = {1'b0, x_i}
                         + {1'b0, y_eff}
                         + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/mod_addsub.sv
// (a +/- b) mod m using one limb-wide carry chain run twice:
// raw sum/difference first, then the modulus correction.
module mod_addsub
  import mod_arith_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int LIMB_W = LIMB_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int NLIMB = nlimb(WIDTH, LIMB_W);
  localparam int W_INT = NLIMB * LIMB_W;
  localparam int CW    = $clog2(NLIMB + 1);
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [W_INT-1:0] a_q, b_q, m_q, s_q;
  logic             sub_q, c_q, cout1_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q, busy_q;

  logic              pass2;
  logic [LIMB_W-1:0] x_d, y_d, sum;
  logic              inv_d, cout;
  logic [W_INT-1:0]  s_shift_d, s_rot_d, t_d;
  logic              use_t_d;
  logic [WIDTH-1:0]  result_d;

  assign pass2 = (state_q == PASS2);
  assign x_d   = pass2 ? s_q[LIMB_W-1:0] : a_q[LIMB_W-1:0];
  assign y_d   = pass2 ? m_q[LIMB_W-1:0] : b_q[LIMB_W-1:0];
  assign inv_d = pass2 ? ~sub_q : sub_q;

  limb_adder #(
    .W(LIMB_W)
  ) u_add (
    .x_i    (x_d),
    .y_i    (y_d),
    .inv_y_i(inv_d),
    .cin_i  (c_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // s is built LSB-first in pass 1, then rotated so it survives pass 2
  assign s_shift_d = {sum, s_q[W_INT-1:LIMB_W]};
  assign s_rot_d   = {s_q[LIMB_W-1:0], s_q[W_INT-1:LIMB_W]};
  assign t_d       = {sum, b_q[W_INT-1:LIMB_W]};

  // add: t valid when s >= m; sub: t valid when a - b went negative
  assign use_t_d  = sub_q ? ~cout1_q : cout;
  assign result_d = use_t_d ? t_d[WIDTH-1:0] : s_rot_d[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      cout1_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= W_INT'(in_a);
            b_q     <= W_INT'(in_b);
            m_q     <= W_INT'(in_m);
            s_q     <= '0;
            sub_q   <= subtract;
            c_q     <= subtract;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          a_q   <= a_q >> LIMB_W;
          b_q   <= b_q >> LIMB_W;
          s_q   <= s_shift_d;
          c_q   <= cout;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout1_q <= cout;
            cnt_q   <= '0;
            c_q     <= ~sub_q;
            state_q <= PASS2;
          end
        end
        PASS2: begin
          m_q   <= m_q >> LIMB_W;
          s_q   <= s_rot_d;
          b_q   <= t_d;
          c_q   <= cout;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
